if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 162 ++++++++++++++++
 tb/tb_if_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage with a single IF/ID register.
//
// Fetches one word per request from a request/acknowledge instruction
// memory and hands it to decode through the IF/ID register. A one-word
// skid buffer holds a fetched word while decode is stalled. A redirect
// (taken branch/jump) flushes the stage and restarts fetch at the new
// address. If a request is still outstanding when the redirect arrives,
// that request is drained and its data is thrown away.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   stall               decode not accepting the IF/ID word
//   redirect            flush and restart fetch at redirect_pc
//   redirect_pc[31:0]   new fetch address (bits [1:0] ignored)
//   imem_req            memory request, held until imem_ack
//   imem_addr[31:0]     word-aligned fetch address
//   imem_ack            memory completion; imem_rdata valid this cycle
//   imem_rdata[31:0]    fetched instruction
//   if_valid            IF/ID holds a live instruction
//   if_instr[31:0]      IF/ID instruction
//   if_pc4[31:0]        address of the held instruction + 4
//   opcode[5:0]         if_instr[31:26]
//   funct[5:0]          if_instr[5:0]
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_REQ   = 2'd1,
    S_BUF   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  // Holds the stalled fetched word in S_BUF. In S_DRAIN it holds the
  // address of the abandoned request, because pc already points at the
  // redirect target.
  logic [31:0] buffer;

  logic        out_free;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_aligned;
  logic [31:0] reset_aligned;

  assign out_free         = !if_valid || !stall;
  assign pc_plus4         = pc + 32'd4;   // wraps modulo 2^32
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign reset_aligned    = {RESET_PC[31:2], 2'b00};

  // Request outputs decode directly from registered state, so they
  // stay stable for the whole wait and drop at once when rst is asserted.
  assign imem_req  = (state == S_REQ) || (state == S_DRAIN);
  assign imem_addr = (state == S_DRAIN) ? buffer :
                     (state == S_REQ)   ? pc     : 32'h0000_0000;

  assign opcode = if_instr[31:26];
  assign funct  = if_instr[5:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      pc       <= reset_aligned;
      buffer   <= 32'h0000_0000;
      if_valid <= 1'b0;
      if_instr <= 32'h0000_0000;
      if_pc4   <= 32'h0000_0000;
    end else begin
      case (state)
        S_INIT: begin
          // A late ack from before the reset is ignored here.
          state <= S_REQ;
          if (redirect) begin
            pc       <= redirect_aligned;
            if_valid <= 1'b0;
            if_instr <= 32'h0000_0000;
          end else if (out_free) begin
            if_valid <= 1'b0;
          end
        end

        S_REQ: begin
          if (redirect) begin
            // Flush. Data that arrives with the redirect is dropped.
            // Without an ack, drain the request and remember its address.
            if_valid <= 1'b0;
            if_instr <= 32'h0000_0000;
            pc       <= redirect_aligned;
            if (imem_ack) begin
              buffer <= 32'h0000_0000;
              state  <= S_REQ;
            end else begin
              buffer <= pc;
              state  <= S_DRAIN;
            end
          end else if (imem_ack) begin
            pc <= pc_plus4;
            if (out_free) begin
              if_instr <= imem_rdata;
              if_pc4   <= pc_plus4;
              if_valid <= 1'b1;
            end else begin
              buffer <= imem_rdata;
              state  <= S_BUF;
            end
          end else if (out_free) begin
            if_valid <= 1'b0;
          end
        end

        S_BUF: begin
          // pc already points past the buffered word, so pc is its pc+4.
          if (redirect) begin
            if_valid <= 1'b0;
            if_instr <= 32'h0000_0000;
            pc       <= redirect_aligned;
            buffer   <= 32'h0000_0000;
            state    <= S_REQ;
          end else if (out_free) begin
            if_instr <= buffer;
            if_pc4   <= pc;
            if_valid <= 1'b1;
            state    <= S_REQ;
          end
        end

        S_DRAIN: begin
          if (redirect) begin
            pc       <= redirect_aligned;
            if_valid <= 1'b0;
            if_instr <= 32'h0000_0000;
          end else if (out_free) begin
            if_valid <= 1'b0;
          end
          if (imem_ack) begin
            buffer <= 32'h0000_0000;
            state  <= S_REQ;
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  // Second instance: RESET_PC at the top of the address space and
  // zero-wait memory with ack tied high.
  logic        req2;
  logic [31:0] addr2;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc4_2;
  logic [5:0]  opcode2;
  logic [5:0]  funct2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc4(if_pc4), .opcode(opcode), .funct(funct)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0000_0000), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(32'hC0DE_0000), .if_valid(valid2),
    .if_instr(instr2), .if_pc4(pc4_2), .opcode(opcode2), .funct(funct2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #12;
    // Reset state
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc4",   if_pc4, 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_req2",  {31'd0, req2}, 32'd0);
    step();
    rst = 1'b0;
    imem_ack = 1'b1;
    step();   // S_INIT -> S_REQ
    check("first_req",   {31'd0, imem_req}, 32'd1);
    check("first_addr",  imem_addr, 32'h0);
    check("first_valid", {31'd0, if_valid}, 32'd0);
    check("wrap_addr0",  addr2, 32'hFFFF_FFFC);
    $display("reset released: req=%0b addr=%h", imem_req, imem_addr);

    // Zero-wait streaming
    imem_rdata = 32'h1111_0000; step();
    check("zw0_instr", if_instr, 32'h1111_0000);
    check("zw0_pc4",   if_pc4, 32'h4);
    check("zw0_addr",  imem_addr, 32'h4);
    check("zw0_valid", {31'd0, if_valid}, 32'd1);
    check("wrap_pc4",  pc4_2, 32'h0);
    check("wrap_addr1", addr2, 32'h0);
    check("wrap_valid", {31'd0, valid2}, 32'd1);
    $display("zw fetch: instr=%h pc4=%h next=%h", if_instr, if_pc4, imem_addr);
    imem_rdata = 32'h2222_0004; step();
    check("zw1_pc4",  if_pc4, 32'h8);
    check("zw1_addr", imem_addr, 32'h8);
    check("wrap_pc4b", pc4_2, 32'h4);
    $display("zw fetch: instr=%h pc4=%h next=%h", if_instr, if_pc4, imem_addr);
    imem_rdata = 32'h3333_0008; step();
    check("zw2_pc4",  if_pc4, 32'hC);
    check("zw2_addr", imem_addr, 32'hC);
    $display("zw fetch: instr=%h pc4=%h next=%h", if_instr, if_pc4, imem_addr);
    imem_rdata = 32'h4444_000C; step();
    check("zw3_instr", if_instr, 32'h4444_000C);
    check("zw3_pc4",   if_pc4, 32'h10);
    check("zw3_valid", {31'd0, if_valid}, 32'd1);
    $display("zw fetch: instr=%h pc4=%h next=%h", if_instr, if_pc4, imem_addr);

    // Two wait states, then ack with an R-type add word
    imem_ack = 1'b0; imem_rdata = 32'h0000_0020; step();
    check("ws_valid0", {31'd0, if_valid}, 32'd0);
    check("ws_addr0",  imem_addr, 32'h10);
    step();
    check("ws_addr1",  imem_addr, 32'h10);
    check("ws_req1",   {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; step();
    check("ws_valid",  {31'd0, if_valid}, 32'd1);
    check("ws_opcode", {26'd0, opcode}, 32'd0);
    check("ws_funct",  {26'd0, funct}, 32'h20);
    check("ws_pc4",    if_pc4, 32'h14);
    $display("wait-state fetch: instr=%h opcode=%h funct=%h", if_instr, opcode, funct);

    // Stall while an ack arrives -> buffered word
    stall = 1'b1; imem_rdata = 32'h5555_0014; step();
    check("st_req0",   {31'd0, imem_req}, 32'd0);
    check("st_instr0", if_instr, 32'h0000_0020);
    check("st_pc4_0",  if_pc4, 32'h14);
    imem_rdata = 32'hDEAD_BEEF; step();   // ack ignored in S_BUF
    check("st_instr1", if_instr, 32'h0000_0020);
    check("st_req1",   {31'd0, imem_req}, 32'd0);
    step();
    check("st_instr2", if_instr, 32'h0000_0020);
    stall = 1'b0; imem_ack = 1'b0; step();
    check("st_buf_instr", if_instr, 32'h5555_0014);
    check("st_buf_pc4",   if_pc4, 32'h18);
    check("st_addr",      imem_addr, 32'h18);
    $display("stall release: instr=%h pc4=%h next=%h", if_instr, if_pc4, imem_addr);

    // Redirect during an outstanding request -> drain
    redirect = 1'b1; redirect_pc = 32'h0000_0103; step();
    check("rd_valid", {31'd0, if_valid}, 32'd0);
    check("rd_instr", if_instr, 32'h0);
    check("rd_addr",  imem_addr, 32'h18);
    redirect = 1'b0; step();
    check("rd_addr_hold", imem_addr, 32'h18);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; step();
    check("rd_discard_valid", {31'd0, if_valid}, 32'd0);
    check("rd_discard_instr", if_instr, 32'h0);
    check("rd_new_addr",      imem_addr, 32'h100);
    imem_rdata = 32'h7777_0100; step();
    check("rd_fetch_instr", if_instr, 32'h7777_0100);
    check("rd_fetch_pc4",   if_pc4, 32'h104);
    $display("after redirect: instr=%h pc4=%h", if_instr, if_pc4);

    // Redirect coinciding with ack -> data dropped, stay in S_REQ
    redirect = 1'b1; redirect_pc = 32'h0000_020B; imem_rdata = 32'hBAD0_BAD0; step();
    redirect = 1'b0;
    check("ra_valid", {31'd0, if_valid}, 32'd0);
    check("ra_instr", if_instr, 32'h0);
    check("ra_addr",  imem_addr, 32'h208);
    check("ra_req",   {31'd0, imem_req}, 32'd1);
    imem_rdata = 32'h9999_0208; step();
    check("ra_fetch", if_instr, 32'h9999_0208);

    // Asynchronous reset mid-stream, late ack ignored
    imem_ack = 1'b0; #2; rst = 1'b1; #1;
    check("ar_valid", {31'd0, if_valid}, 32'd0);
    check("ar_instr", if_instr, 32'h0);
    check("ar_pc4",   if_pc4, 32'h0);
    check("ar_req",   {31'd0, imem_req}, 32'd0);
    check("ar_addr",  imem_addr, 32'h0);
    $display("async reset: valid=%0b instr=%h req=%0b", if_valid, if_instr, imem_req);
    imem_ack = 1'b1; imem_rdata = 32'hFEED_FACE; step();
    rst = 1'b0; step();   // S_INIT with ack high
    check("ar_late_ack_valid", {31'd0, if_valid}, 32'd0);
    check("ar_restart_addr",   imem_addr, 32'h0);
    imem_rdata = 32'hABCD_0000; step();
    check("ar_restart_instr", if_instr, 32'hABCD_0000);
    check("ar_restart_pc4",   if_pc4, 32'h4);
    $display("restart: instr=%h pc4=%h", if_instr, if_pc4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
